icache_dm: RTL
==============

Name: icache_dm

Overview:
Parametrised direct-mapped instruction cache between the fetch stage and a word-wide backing instruction memory. Replaces the fixed ROM-style instruction store. Hits return in one cycle, matching the current registered-read timing. Misses stall fetch while a full line is refilled from backing memory. Adds valid bits, a flush request and a saturating miss counter.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, instruction word width; fixed at 32 for this generation
LINES, 16, number of cache lines; power of 2, 2 or more
WORDS_PER_LINE, 4, words per line; power of 2, 2 or more

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
cpu_req  in  1  fetch request; valid only while cpu_ready=1
cpu_addr  in  ADDR_W  byte fetch address; bits [1:0] ignored
cpu_ready  out  1  cache can accept a request this cycle
cpu_rvalid  out  1  one-cycle pulse: cpu_rdata is valid
cpu_rdata  out  DATA_W  fetched instruction word, registered
flush  in  1  invalidate all lines
mem_req  out  1  backing-memory word read request
mem_addr  out  ADDR_W  word-aligned backing-memory address
mem_ack  in  1  mem_rdata valid this cycle; completes current word
mem_rdata  in  DATA_W  backing-memory read data
miss_count  out  16  saturating count of misses

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Address split:
  - OFF = log2(WORDS_PER_LINE) + 2.
  - word select = addr[OFF-1:2].
  - index = addr[OFF+log2(LINES)-1:OFF].
  - tag = remaining upper bits.
- Storage: per line, one valid bit, one tag and WORDS_PER_LINE data words. Tag compare is combinational on cpu_addr.
- Reset:
  - state goes to IDLE and all valid bits clear.
  - cpu_rvalid=0, cpu_rdata=0, mem_req=0, mem_addr=0, miss_count=0, pending flush cleared.
  - cpu_ready=1 from the first cycle after reset.
  - Data and tag arrays need no reset.
- FSM states: IDLE, REFILL, RESPOND.
- IDLE:
  - cpu_ready=1 unless flush=1.
  - flush=1: clear all valid bits this cycle. A coincident cpu_req is NOT accepted.
  - cpu_req=1 with valid and tag match (hit): next cycle cpu_rdata = stored word and cpu_rvalid=1. Stay in IDLE, so back-to-back hits sustain one per cycle.
  - cpu_req=1 with miss:
    - latch cpu_addr.
    - miss_count increments, saturating at 16'hFFFF.
    - clear the valid bit of the indexed line.
    - word counter = 0.
    - go to REFILL.
- REFILL:
  - cpu_ready=0.
  - mem_req=1 and mem_addr = line base + 4*counter. Both stay stable until mem_ack.
  - On mem_ack: write mem_rdata into word[counter]. If counter equals the requested word, also load cpu_rdata.
  - On the ack of the last word: set valid, write tag, drop mem_req next cycle, go to RESPOND. Otherwise counter+1.
  - Line fill order is always word 0 to word N-1; no critical-word-first.
- RESPOND:
  - cpu_rvalid=1 for exactly one cycle and cpu_ready=0; next state IDLE.
  - Miss latency from request cycle: sum of ack waits + 1 cycle.
- cpu_rvalid is 0 in every cycle not listed above. cpu_rdata holds its last value.
- mem_ack while mem_req=0 is ignored.
- cpu_req outside IDLE is ignored; the requester must hold or re-present it.
- flush outside IDLE sets a pending flag. The flag is applied on the first IDLE cycle, including invalidating the line just refilled. That cycle behaves as flush=1 (request not accepted).
- rst mid-refill aborts the refill: mem_req=0 next cycle and the line stays invalid. No partial line is ever marked valid.

Test Plan:
Test parameters: LINES=16, WORDS_PER_LINE=4, so index=addr[7:4] and tag=addr[31:8]. The memory model returns word(a) = 32'h20000000|a with mem_ack one cycle after mem_req.

1. Cold miss: rst, then read 0x04.
   - mem_addr sequence 0x00, 0x04, 0x08, 0x0C, each held until its ack.
   - One cycle after the last ack: cpu_rvalid=1, cpu_rdata=0x20000004, miss_count=1.
2. Streaming hits: after scenario 1, present 0x00, 0x08, 0x0C on consecutive cycles.
   - cpu_rvalid=1 on each following cycle with data 0x20000000, 0x20000008, 0x2000000C.
   - mem_req stays 0 and miss_count stays 1.
3. Conflict: read 0x100, then 0x00.
   - Refill of 0x100–0x10C, then a refill of 0x00–0x0C.
   - miss_count=3 and cpu_rdata=0x20000000.
4. Flush: flush=1 with cpu_req=1 for 0x00 in IDLE.
   - cpu_ready=0 that cycle and the request is not accepted.
   - A later read of 0x00 misses and refills.
   - Repeat with flush pulsed during REFILL: the following read of the same line misses again.
5. Slow memory: mem_ack delayed 3 cycles per word.
   - mem_req and mem_addr are stable across the waits.
   - cpu_rvalid arrives 17 cycles after the request is accepted.
   - A spurious mem_ack while mem_req=0 changes nothing.
6. Reset mid-refill: rst after 2 acks.
   - mem_req=0 and cpu_rvalid=0 the next cycle and miss_count=0.
   - Re-read of 0x04 misses and performs a full 4-word refill.
   - Preload miss_count near 16'hFFFF via repeated conflicts and confirm it saturates.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache between fetch and a word-wide backing memory.
// Latency: hit data one cycle after the request; miss = sum of refill ack waits + 1.
// Backpressure: cpu_ready low outside IDLE or while a flush applies; mem_req held until mem_ack.
module icache_dm #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       miss_count
);
    localparam int WSEL_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(LINES);
    localparam int OFF    = WSEL_W + 2;
    localparam int TAG_W  = ADDR_W - OFF - IDX_W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REFILL  = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    logic [1:0]        state;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES*WORDS_PER_LINE];
    logic [ADDR_W-1:2] miss_addr;
    logic [WSEL_W-1:0] cnt;
    logic              flush_pend;

    logic [WSEL_W-1:0] c_wsel, m_wsel;
    logic [IDX_W-1:0]  c_idx, m_idx;
    logic [TAG_W-1:0]  c_tag, m_tag;
    logic              hit, flush_now, fill_ack, last_word;
    logic              unused_addr_bits;

    assign c_wsel = cpu_addr[OFF-1:2];
    assign c_idx  = cpu_addr[OFF+IDX_W-1:OFF];
    assign c_tag  = cpu_addr[ADDR_W-1:OFF+IDX_W];
    assign m_wsel = miss_addr[OFF-1:2];
    assign m_idx  = miss_addr[OFF+IDX_W-1:OFF];
    assign m_tag  = miss_addr[ADDR_W-1:OFF+IDX_W];
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign hit       = valid[c_idx] && (tag_mem[c_idx] == c_tag);
    assign flush_now = flush || flush_pend;
    assign cpu_ready = (state == S_IDLE) && !flush_now;
    assign fill_ack  = (state == S_REFILL) && mem_ack;
    assign last_word = (cnt == WSEL_W'(WORDS_PER_LINE - 1));

    // Storage arrays carry no reset so they map onto plain RAM.
    always_ff @(posedge clk) begin
        if (fill_ack) begin
            data_mem[{m_idx, cnt}] <= mem_rdata;
            if (last_word) tag_mem[m_idx] <= m_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            valid      <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            miss_count <= '0;
            flush_pend <= 1'b0;
            miss_addr  <= '0;
            cnt        <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            if (state != S_IDLE && flush) flush_pend <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (flush_now) begin
                        valid      <= '0;
                        flush_pend <= 1'b0;
                    end else if (cpu_req) begin
                        if (hit) begin
                            cpu_rdata  <= data_mem[{c_idx, c_wsel}];
                            cpu_rvalid <= 1'b1;
                        end else begin
                            miss_addr    <= cpu_addr[ADDR_W-1:2];
                            valid[c_idx] <= 1'b0;
                            cnt          <= '0;
                            mem_req      <= 1'b1;
                            mem_addr     <= {cpu_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
                            state        <= S_REFILL;
                            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                        end
                    end
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        if (cnt == m_wsel) cpu_rdata <= mem_rdata;
                        if (last_word) begin
                            valid[m_idx] <= 1'b1;
                            mem_req      <= 1'b0;
                            cpu_rvalid   <= 1'b1;
                            state        <= S_RESPOND;
                        end else begin
                            cnt      <= cnt + WSEL_W'(1);
                            mem_addr <= mem_addr + ADDR_W'(4);
                        end
                    end
                end
                S_RESPOND: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end
endmodule
